// File: rtl/trax_pkg.sv
// trax_pkg: ASCII bytes, tile encodings and transmitter states shared by the Trax move-text link
package trax_pkg;
  localparam logic [7:0] DASH   = 8'd45;
  localparam logic [7:0] W      = 8'd87;
  localparam logic [7:0] B      = 8'd66;
  localparam logic [7:0] NL     = 8'd10;
  localparam logic [7:0] AT     = 8'd64;
  localparam logic [7:0] ZERO   = 8'd48;
  localparam logic [7:0] PLUS   = 8'd43;
  localparam logic [7:0] SLASH  = 8'd47;
  localparam logic [7:0] BSLASH = 8'd92;

  typedef enum logic [1:0] {
    TYPE_PLUS   = 2'd0,
    TYPE_SLASH  = 2'd1,
    TYPE_BSLASH = 2'd2
  } tile_t;

  typedef enum logic [2:0] {
    IDLE, HDR, CONV, EMIT_X, EMIT_Y, EMIT_T, EMIT_NL
  } state_t;

  // Unused encoding 3 falls back to '+'
  function automatic logic [7:0] type_char(input logic [1:0] t);
    return t == TYPE_SLASH ? SLASH : t == TYPE_BSLASH ? BSLASH : PLUS;
  endfunction
endpackage

// File: rtl/radix_stack.sv
// radix_stack: converts a value to (optionally bijective) base-RADIX digits into a LIFO, then pops MSD first
module radix_stack #(
  parameter int RADIX     = 10,
  parameter bit BIJECTIVE = 1'b0,
  parameter int DEPTH     = 4,
  parameter int W         = 11,
  localparam int DW       = $clog2(RADIX + 1)
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [W-1:0]  val_i,
  input  logic          pop_i,
  output logic          ready_o,
  output logic [DW-1:0] top_o,
  output logic [DW-1:0] next_o,
  output logic          single_o
);
  localparam int SW = $clog2(DEPTH + 1);

  logic [W-1:0]  n_q, quo, rem, n_nx;
  logic [DW-1:0] dig;
  logic          conv_q, wrap, last;
  logic [SW-1:0] sp_q;
  logic [DW-1:0] stk_q [2**SW];

  // One digit per cycle; a zero value still yields a single digit 0.
  // top_o forwards the digit being pushed so the caller can present it on the finishing edge.
  always_comb begin
    quo      = n_q / W'(RADIX);
    rem      = n_q % W'(RADIX);
    wrap     = BIJECTIVE && n_q != '0 && rem == '0;
    dig      = n_q == '0 ? '0 : wrap ? DW'(RADIX) : DW'(rem);
    n_nx     = wrap ? quo - W'(1) : quo;
    last     = n_nx == '0;
    ready_o  = ~conv_q | last;
    top_o    = conv_q ? dig : stk_q[sp_q - SW'(1)];
    next_o   = stk_q[sp_q - SW'(2)];
    single_o = sp_q == SW'(1);
  end

  // Conversion counter and stack pointer; load discards any leftover digits
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q    <= '0;
      conv_q <= 1'b0;
      sp_q   <= '0;
    end else if (load_i) begin
      n_q    <= val_i;
      conv_q <= 1'b1;
      sp_q   <= '0;
    end else if (conv_q) begin
      n_q    <= n_nx;
      conv_q <= ~last;
      sp_q   <= sp_q + SW'(1);
    end else if (pop_i) begin
      sp_q <= sp_q - SW'(1);
    end
  end

  // Digit storage needs no reset; the pointer alone defines what is valid
  always_ff @(posedge clk) begin
    if (conv_q) stk_q[sp_q] <= dig;
  end
endmodule

// File: rtl/send_order.sv
// send_order: serialises a Trax move or colour header into ASCII bytes with valid/accept backpressure
module send_order
  import trax_pkg::*;
#(
  parameter int x_width = 10,
  parameter int MAX_COL = 3,
  parameter int MAX_ROW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_valid,
  input  logic             hdr_white,
  output logic             hdr_ready,
  input  logic             move_valid,
  output logic             move_ready,
  input  logic [x_width:0] move_x,
  input  logic [x_width:0] move_y,
  input  logic [1:0]       move_type,
  output logic [7:0]       outData,
  output logic             dataValid,
  input  logic             dataAccept,
  output logic             busy,
  output logic             tx_done
);
  localparam int XW = x_width + 1;

  state_t      state_q;
  logic [7:0]  out_q;
  logic        valid_q, done_q, white_q;
  logic [1:0]  hdr_idx_q, type_q;
  logic        idle, move_acc, xfer, col_pop, row_pop;
  logic        col_rdy, row_rdy, col_single, row_single;
  logic [4:0]  col_top, col_next;
  logic [3:0]  row_top, row_next;

  // Handshake decode; the header wins when both requests are pending
  always_comb begin
    idle       = state_q == IDLE;
    hdr_ready  = idle;
    move_ready = idle & ~hdr_valid;
    move_acc   = move_valid & move_ready;
    xfer       = valid_q & dataAccept;
    col_pop    = state_q == EMIT_X & xfer;
    row_pop    = state_q == EMIT_Y & xfer;
    busy       = ~idle;
    outData    = out_q;
    dataValid  = valid_q;
    tx_done    = done_q;
  end

  radix_stack #(.RADIX(26), .BIJECTIVE(1'b1), .DEPTH(MAX_COL), .W(XW)) u_col (
    .clk(clk), .rst_ni(reset), .load_i(move_acc), .val_i(move_x), .pop_i(col_pop),
    .ready_o(col_rdy), .top_o(col_top), .next_o(col_next), .single_o(col_single)
  );

  radix_stack #(.RADIX(10), .BIJECTIVE(1'b0), .DEPTH(MAX_ROW), .W(XW)) u_row (
    .clk(clk), .rst_ni(reset), .load_i(move_acc), .val_i(move_y), .pop_i(row_pop),
    .ready_o(row_rdy), .top_o(row_top), .next_o(row_next), .single_o(row_single)
  );

  // Frame sequencer; each transfer loads the following byte so the link can take one per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      white_q   <= 1'b0;
      hdr_idx_q <= '0;
      type_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hdr_valid) begin
            state_q   <= HDR;
            out_q     <= DASH;
            valid_q   <= 1'b1;
            white_q   <= hdr_white;
            hdr_idx_q <= '0;
          end else if (move_valid) begin
            state_q <= CONV;
            type_q  <= move_type;
          end
        end
        HDR: if (xfer) begin
          hdr_idx_q <= hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd0) out_q <= white_q ? W : B;
          else if (hdr_idx_q == 2'd1) out_q <= NL;
          else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        CONV: if (col_rdy && row_rdy) begin
          state_q <= EMIT_X;
          out_q   <= AT + 8'(col_top);
          valid_q <= 1'b1;
        end
        EMIT_X: if (xfer) begin
          state_q <= col_single ? EMIT_Y : EMIT_X;
          out_q   <= col_single ? ZERO + 8'(row_top) : AT + 8'(col_next);
        end
        EMIT_Y: if (xfer) begin
          state_q <= row_single ? EMIT_T : EMIT_Y;
          out_q   <= row_single ? type_char(type_q) : ZERO + 8'(row_next);
        end
        EMIT_T: if (xfer) begin
          state_q <= EMIT_NL;
          out_q   <= NL;
        end
        EMIT_NL: if (xfer) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
